// File: rtl/cla_serial_add_if.sv
// cla_serial_add_if: operand/result handshake bundle for the serial CLA add controller
interface cla_serial_add_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             busy;
    modport master (
        output in_valid, op_a, op_b, sub, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, ovf, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, sub, c_in, out_ready,
        output in_ready, out_valid, result, c_out, ovf, busy
    );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: WIDTH-bit add/sub by time-sharing one 4-bit carry-look-ahead adder, LSB nibble first
module carry_look_ahead_adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g, p, c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);
    assign sum = p ^ c;
endmodule

module cla_serial_add_ctrl #(parameter int WIDTH = 16) (
    input logic            clk,
    input logic            rst_n,
    cla_serial_add_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [3:0]       a_nib, b_nib, sum_nib;
    logic             cy_nib;
    logic             last;

    // pick the operand nibbles addressed by the current pass
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++)
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
    end

    assign last = idx_q == IW'(NIBBLES - 1);

    carry_look_ahead_adder_4bits u_cla (
        .a(a_nib), .b(b_nib), .c_in(carry_q), .sum(sum_nib), .c_out(cy_nib)
    );

    // sequencer: accept operands, run one nibble per cycle, hold the result until taken
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d      = bus.op_a;
                b_d      = bus.sub ? ~bus.op_b : bus.op_b;
                carry_d  = bus.sub | bus.c_in;
                idx_d    = '0;
                result_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++)
                    if (idx_q == IW'(i)) result_d[4*i +: 4] = sum_nib;
                carry_d = cy_nib;
                if (last) begin
                    c_out_d     = cy_nib;
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nib[3] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb_cla_serial_add_ctrl: directed and random checks of the serial CLA adder against an arithmetic model
module tb_cla_serial_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;
    always #5 clk = ~clk;

    cla_serial_add_if #(.WIDTH(W)) bus ();
    cla_serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // plain arithmetic reference: wide add/sub and signed range check
    function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                     input logic ci, output logic [W-1:0] r, output logic c, output logic o);
        longint sa, sb, t;
        logic [W:0] f;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r = a - b;
            c = a >= b;
            t = sa - sb;
        end else begin
            f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r = f[W-1:0];
            c = f[W];
            t = sa + sb + longint'(ci);
        end
        o = (t > (longint'(1) <<< (W - 1)) - 1) || (t < -(longint'(1) <<< (W - 1)));
    endfunction

    // model: 0 = waiting, 1 = computing (N cycles), 2 = presenting
    int m_phase = 0;
    int m_cnt = 0;
    logic m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic m_c = 1'b0;
    logic m_ovf = 1'b0;
    logic [W-1:0] p_res;
    logic p_c, p_ovf;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_valid = 1'b0; m_res = '0; m_c = 1'b0; m_ovf = 1'b0;
        end else if (m_phase == 0) begin
            if (bus.in_valid) begin
                ref_calc(bus.op_a, bus.op_b, bus.sub, bus.c_in, p_res, p_c, p_ovf);
                m_cnt = N;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_res = p_res; m_c = p_c; m_ovf = p_ovf; m_valid = 1'b1; m_phase = 2;
            end
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
            m_phase = 0;
        end
    end

    // compare every cycle against the model
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("c_out", 32'(bus.c_out), 32'(m_c));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            if (m_phase != 1) chk("result", 32'(bus.result), 32'(m_res));
        end
    end

    task automatic scramble();
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
        bus.sub  = 1'($urandom);
        bus.c_in = 1'($urandom);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                         input logic [W-1:0] er, input logic ec, input logic eo, input int hold);
        int n;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s; bus.c_in = ci; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble();
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(N));
        chk("lit_result", 32'(bus.result), 32'(er));
        chk("lit_c_out", 32'(bus.c_out), 32'(ec));
        chk("lit_ovf", 32'(bus.ovf), 32'(eo));
        repeat (hold) begin
            @(posedge clk); #1;
            bus.in_valid = ~bus.in_valid;
            scramble();
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_result", 32'(bus.result), 32'(er));
            chk("bp_flags", {30'd0, bus.c_out, bus.ovf}, {30'd0, ec, eo});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("drop_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 3);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h0002, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op_a = 16'hFFFF; bus.op_b = 16'h0001; bus.sub = 1'b0; bus.c_in = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_flags", {30'd0, bus.c_out, bus.ovf}, 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom);
            scramble();
            if ($urandom_range(0, 3) == 0) bus.op_a = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h7FFF;
            if ($urandom_range(0, 3) == 0) bus.op_b = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0001;
            bus.out_ready = $urandom_range(0, 2) != 0;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
Sequencer that time-shares one carry_look_ahead_adder_4bits instance to perform WIDTH-bit add/subtract, one nibble per clock, LSB nibble first. The carry is registered between nibbles. Operands enter on a valid/ready handshake; results leave on a separate valid/ready handshake. The block sits in the arithmetic datapath wherever a wide add is needed at low area cost.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and >= 8
NIBBLES, WIDTH/4, derived localparam: number of adder passes per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  1 = A - B, 0 = A + B + c_in
c_in  input  1  carry-in for add; ignored when sub=1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference
c_out  output  1  carry out of MSB (for sub: 1 = no borrow, i.e. A >= B unsigned)
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; nibble index = 0; carry reg = 0.
  - result, c_out, ovf, out_valid = 0.
  - in_ready is decoded as (state==IDLE), so it is 1 while in reset.
  - Reset mid-operation aborts the operation. No partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k:
    - latch A into a_reg.
    - latch B into b_reg, using ~op_b when sub=1.
    - carry reg <= (sub ? 1 : c_in).
    - idx <= 0; result <= 0; state <= RUN.
- RUN:
  - in_ready=0; incoming in_valid is ignored.
  - The adder is driven combinationally with a = a_reg[4*idx+:4], b = b_reg[4*idx+:4], c_in = carry reg.
  - Each edge: result[4*idx+:4] <= adder sum; carry reg <= adder c_out; idx <= idx+1.
  - On the edge where idx == NIBBLES-1:
    - c_out <= adder c_out.
    - ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (final sum bit 3 != a_reg[WIDTH-1]).
    - out_valid <= 1; state <= DONE.
- Latency: operand accepted at edge k, out_valid is high after edge k+NIBBLES (4 cycles for WIDTH=16). Throughput is one operation per NIBBLES+2 cycles at best.
- DONE:
  - out_valid=1.
  - result, c_out, ovf are held stable until out_valid&&out_ready.
  - On that edge: out_valid <= 0; state <= IDLE. in_ready is high the following cycle.
  - No accept in DONE (in_ready=0), so a simultaneous in_valid is not taken.
- Outputs are registered; result/c_out/ovf keep their last values in IDLE.
- idx width is clog2(NIBBLES) (minimum 1). idx never exceeds NIBBLES-1; no wrap in RUN.
- Arithmetic is modulo 2^WIDTH. The carry chain across nibbles must equal a full WIDTH-bit add.

Test Plan:
1. WIDTH=16, add a=0x1234, b=0x4321, c_in=0 -> result 0x5555, c_out 0, ovf 0; out_valid rises exactly 4 cycles after the accept edge.
2. Add a=0xFFFF, b=0x0001, c_in=0 -> result 0x0000, c_out 1, ovf 0 (carry ripples through all 4 nibbles). Add a=0x0002, b=0x0004, c_in=1 -> 0x0007, c_out 0.
3. Add a=0x7FFF, b=0x0001, c_in=0 -> result 0x8000, ovf 1, c_out 0.
4. Sub a=0x0005, b=0x0007 -> 0xFFFE, c_out 0, ovf 0. Sub a=0x8000, b=0x0001 -> 0x7FFF, c_out 1, ovf 1. In both cases c_in is driven to 1 and ignored.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid while pulsing in_valid with new operands -> out_valid, result, flags stable; in_ready 0; new operands not accepted. Then raise out_ready -> out_valid drops next edge and in_ready=1 the following cycle.
6. Assert rst_n low after 2 nibbles of a=0xFFFF + 0x0001 -> out_valid, result, c_out, ovf 0 immediately, busy 0. After release, a=0x0100 + 0x0100 -> 0x0200 with correct 4-cycle latency.
